// File: rtl/sign_ext_pkg.sv
// Shared widths and mode encoding for the MIPS32 immediate-extension stage.
// The LUI mode is only honoured when SIGNEXT_LUI_EN is defined.
package sign_ext_pkg;

  localparam int unsigned IMM_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    SEXT     = 2'b00,
    ZEXT     = 2'b01,
    SEXT_SL2 = 2'b10,
    LUI      = 2'b11
  } mode_e;

endpackage

// File: rtl/sign_ext_if.sv
// Operand/result bundle for sign_ext; the master drives the immediate and mode,
// the slave returns the registered extended value.
interface sign_ext_if;
  import sign_ext_pkg::*;

  logic [IMM_W-1:0]  a;
  logic [MODE_W-1:0] mode;
  logic              in_valid;
  logic [DATA_W-1:0] y;
  logic              out_valid;

  modport master (output a, output mode, output in_valid, input y, input out_valid);
  modport slave  (input a, input mode, input in_valid, output y, output out_valid);
endinterface

// File: rtl/sign_ext_core.sv
// Combinational mode decode and immediate extension.
// With SIGNEXT_LUI_EN undefined, mode 11 falls through to sign extension.
module sign_ext_core
  import sign_ext_pkg::*;
(
  input  logic [IMM_W-1:0]  i_a,
  input  logic [MODE_W-1:0] i_mode,
  output logic [DATA_W-1:0] o_y_c
);

  localparam int unsigned EXT_W = DATA_W - IMM_W;
  localparam int unsigned SL2_W = EXT_W - 2;

  // Sign extension is the default so any undecoded mode behaves as SEXT.
  always_comb begin
    o_y_c = {{EXT_W{i_a[IMM_W-1]}}, i_a};
    case (mode_e'(i_mode))
      ZEXT:     o_y_c = {{EXT_W{1'b0}}, i_a};
      SEXT_SL2: o_y_c = {{SL2_W{i_a[IMM_W-1]}}, i_a, 2'b00};
`ifdef SIGNEXT_LUI_EN
      LUI:      o_y_c = {i_a, {EXT_W{1'b0}}};
`endif
      default:  ;
    endcase
  end

endmodule

// File: rtl/sign_ext.sv
// Immediate-extension stage: one registered 32-bit result per cycle, latency 1.
// Optional upper-immediate form enabled by SIGNEXT_LUI_EN.
module sign_ext
  import sign_ext_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  sign_ext_if.slave io_bus
);

  logic [DATA_W-1:0] w_y_c;
  logic [DATA_W-1:0] r_y;
  logic              r_out_valid;

  sign_ext_core u_core (
    .i_a    (io_bus.a),
    .i_mode (io_bus.mode),
    .o_y_c  (w_y_c)
  );

  // y only loads on a valid operand, so idle-cycle garbage on a never reaches it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_y         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= io_bus.in_valid;
      if (io_bus.in_valid) begin
        r_y <= w_y_c;
      end
    end
  end

  assign io_bus.y         = r_y;
  assign io_bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_sign_ext.sv
// Self-checking bench for sign_ext: directed literal cases plus randomized
// stream compared every cycle against an arithmetic reference model.
module tb_sign_ext;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  sign_ext_if u_if ();

  sign_ext dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: build values with integer arithmetic rather than bit slicing.
  function automatic logic [31:0] model(input logic [15:0] a, input logic [1:0] m);
    int unsigned z;
    int          s;
    z = 32'(a);
    s = (a >= 16'h8000) ? int'(z) - 65536 : int'(z);
    case (m)
      2'd0:    return 32'(s);
      2'd1:    return z;
      2'd2:    return 32'(s * 4);
`ifdef SIGNEXT_LUI_EN
      default: return z * 32'd65536;
`else
      default: return 32'(s);
`endif
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] exp_y;
  logic        exp_v;
  logic        model_on;

  initial begin
    model_on = 1'b0;
    exp_y    = '0;
    exp_v    = 1'b0;
  end

  // Model update at each active edge.
  always @(posedge clk) begin
    if (reset) begin
      exp_y    = '0;
      exp_v    = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      exp_v = u_if.in_valid;
      if (u_if.in_valid) exp_y = model(u_if.a, u_if.mode);
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      chk("model_out_valid", 32'(u_if.out_valid), 32'(exp_v));
      chk("model_y", u_if.y, exp_y);
    end
  end

  // Drive at negedge; result is visible at the following negedge.
  task automatic step(input logic r, input logic v, input logic [15:0] a, input logic [1:0] m);
    reset       = r;
    u_if.in_valid = v;
    u_if.a      = a;
    u_if.mode   = m;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_lit(input string name, input logic [31:0] y, input logic v);
    chk({name, "_y"}, u_if.y, y);
    chk({name, "_valid"}, 32'(u_if.out_valid), 32'(v));
  endtask

  logic [31:0] lui_exp;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    u_if.in_valid = 1'b0;
    u_if.a   = '0;
    u_if.mode = '0;
    @(negedge clk);

    step(1'b1, 1'b0, 16'h0, 2'd0);
    expect_lit("reset1", 32'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 2'd0);
    expect_lit("reset2", 32'h0, 1'b0);

    step(1'b0, 1'b1, 16'h7FFF, 2'd0);
    expect_lit("sext_7fff", 32'h0000_7FFF, 1'b1);
    step(1'b0, 1'b1, 16'h8000, 2'd0);
    expect_lit("sext_8000", 32'hFFFF_8000, 1'b1);
    step(1'b0, 1'b1, 16'h8000, 2'd1);
    expect_lit("zext_8000", 32'h0000_8000, 1'b1);
    step(1'b0, 1'b1, 16'hFFFF, 2'd2);
    expect_lit("sl2_ffff", 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 1'b1, 16'h0001, 2'd2);
    expect_lit("sl2_0001", 32'h0000_0004, 1'b1);
    step(1'b0, 1'b1, 16'h7FFF, 2'd2);
    expect_lit("sl2_7fff", 32'h0001_FFFC, 1'b1);

`ifdef SIGNEXT_LUI_EN
    lui_exp = 32'h1234_0000;
`else
    lui_exp = 32'h0000_1234;
`endif
    step(1'b0, 1'b1, 16'h1234, 2'd3);
    expect_lit("lui_1234", lui_exp, 1'b1);

    step(1'b0, 1'b1, 16'h0001, 2'd0);
    expect_lit("stream0", 32'h0000_0001, 1'b1);
    step(1'b0, 1'b1, 16'hFFFE, 2'd0);
    expect_lit("stream1", 32'hFFFF_FFFE, 1'b1);
    step(1'b0, 1'b1, 16'h8000, 2'd0);
    expect_lit("stream2", 32'hFFFF_8000, 1'b1);
    step(1'b0, 1'b0, 16'h0F0F, 2'd1);
    expect_lit("hold", 32'hFFFF_8000, 1'b0);
    step(1'b1, 1'b1, 16'h5555, 2'd1);
    expect_lit("reset_over_valid", 32'h0, 1'b0);
    step(1'b0, 1'b1, 16'hABCD, 2'd1);
    expect_lit("first_after_reset", 32'h0000_ABCD, 1'b1);

    // Randomized stream with idle gaps and occasional mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic        v;
      logic [15:0] a;
      logic [1:0]  m;
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 9) < 7);
      a = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
      m = 2'($urandom_range(0, 3));
      step(r, v, a, m);
    end

    step(1'b0, 1'b0, 16'h0, 2'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
